// File: rtl/max_idx_pkg.sv
// Shared definitions for the 10-class argmax handshake: class count, index width, collector states.
// Constants and a label-range helper; no logic, no latency.
package max_idx_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_START   = 3'd1,
        S_ARM     = 3'd2,
        S_WAIT    = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    // A 4-bit label can encode 10..15, none of which is a real class.
    function automatic logic is_valid_label(input logic [IDX_W-1:0] label);
        return label <= IDX_W'(NUM_CLASSES - 1);
    endfunction

endpackage

// File: rtl/class_result_collector_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Single-cycle update, no backpressure.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/class_result_collector.sv
// Buffers 10 serial class scores, runs the external argmax engine, returns index/correct flag and stats.
// Result 7 cycles after the 10th accept; in_ready low and scores frozen until the result is taken.
module class_result_collector
    import max_idx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_score,
    input  logic [3:0]       in_label,
    output logic [WIDTH-1:0] scores [NUM_CLASSES],
    output logic             start,
    input  logic [3:0]       am_idx,
    input  logic             am_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_idx,
    output logic             res_correct,
    output logic [CNT_W-1:0] correct_cnt,
    output logic [CNT_W-1:0] total_cnt,
    input  logic             clear_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [3:0]       label;
    logic             accept;
    logic             update;
    logic             hit;

    assign accept = in_valid && in_ready;
    assign update = (state == S_WAIT) && am_done;
    assign hit    = (am_idx == label) && is_valid_label(label);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_COLLECT;
            cnt         <= '0;
            label       <= '0;
            res_idx     <= '0;
            res_correct <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
                if (cnt == '0) begin
                    label <= in_label;
                end
            end
            if (update) begin
                res_idx     <= am_idx;
                res_correct <= hit;
            end
        end
    end

    // Score buffer carries no reset; only writes in S_COLLECT can change it.
    always_ff @(posedge clk) begin
        if (accept) begin
            scores[cnt] <= in_score;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        start     = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == LAST_IDX)) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                start     = 1'b1;
                state_nxt = S_ARM;
            end
            // am_done may still be high from the previous run; wait for the engine to drop it.
            S_ARM: begin
                if (!am_done) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (am_done) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = S_COLLECT;
                end
            end
            default: begin
                state_nxt = S_COLLECT;
            end
        endcase
    end

    sat_cnt #(.W(CNT_W)) u_total_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (update),
        .clr   (clear_cnt),
        .q     (total_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_correct_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (update && hit),
        .clr   (clear_cnt),
        .q     (correct_cnt)
    );

endmodule

// File: tb/tb_class_result_collector.sv
// Bench for class_result_collector: stub argmax engine plus a vector-level reference model.
module tb_class_result_collector;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_score;
    logic [3:0]    in_label;
    logic [W-1:0]  scores [10];
    logic          start;
    logic [3:0]    am_idx = 4'd0;
    logic          am_done = 1'b0;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_idx;
    logic          res_correct;
    logic [CW-1:0] correct_cnt;
    logic [CW-1:0] total_cnt;
    logic          clear_cnt;

    class_result_collector #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_score    (in_score),
        .in_label    (in_label),
        .scores      (scores),
        .start       (start),
        .am_idx      (am_idx),
        .am_done     (am_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_idx     (res_idx),
        .res_correct (res_correct),
        .correct_cnt (correct_cnt),
        .total_cnt   (total_cnt),
        .clear_cnt   (clear_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int start_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start) start_cnt <= start_cnt + 1;
    end

    // Argmax engine stub: drops done one cycle after start, raises it with the result 5 cycles after start.
    int eng_cnt = 0;
    function automatic logic [3:0] eng_argmax();
        int b = 0;
        for (int i = 1; i < 10; i++)
            if ($signed(scores[i]) > $signed(scores[b])) b = i;
        return 4'(b);
    endfunction

    always @(posedge clk) begin
        if (start) begin
            eng_cnt <= 5;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 5) am_done <= 1'b0;
            if (eng_cnt == 2) begin
                am_done <= 1'b1;
                am_idx  <= eng_argmax();
            end
        end
    end

    // Reference model
    int vec [10];
    int exp_label;
    int m_total = 0;
    int m_correct = 0;
    int checks = 0;
    int failures = 0;

    function automatic int ref_argmax();
        int b = 0;
        for (int i = 1; i < 10; i++)
            if (vec[i] > vec[b]) b = i;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rand_vec();
        logic signed [7:0] r;
        for (int i = 0; i < 10; i++) begin
            r = 8'($urandom);
            vec[i] = r;
        end
    endtask

    task automatic send(input int n, output int acc);
        int t;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_score = 8'(vec[i]);
            in_label = (i == 0) ? 4'(exp_label) : 4'($urandom);
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t == 100) check("send_timeout", 0, 1);
            acc = cyc;
        end
    endtask

    task automatic wait_result(input int acc, input int hold, input bit clr_upd);
        int  exp_idx = ref_argmax();
        bit  exp_c = (exp_idx == exp_label) && (exp_label <= 9);
        int  s0 = start_cnt;
        int  t = 0;
        bit  seen = 0;
        while (!seen && t < 60) begin
            @(negedge clk);
            in_valid  = 1'b0;
            clear_cnt = (clr_upd && cyc == acc + 6);
            t++;
            if (res_valid) seen = 1;
        end
        clear_cnt = 1'b0;
        if (!seen) begin
            check("result_timeout", 0, 1);
            return;
        end
        if (clr_upd) begin
            m_total = 0;
            m_correct = 0;
        end else begin
            if (m_total < SAT) m_total++;
            if (exp_c && m_correct < SAT) m_correct++;
        end
        check("latency", cyc, acc + 7);
        check("start_pulses", start_cnt - s0, 1);
        check("res_idx", res_idx, exp_idx);
        check("res_correct", res_correct, exp_c);
        check("total_cnt", total_cnt, m_total);
        check("correct_cnt", correct_cnt, m_correct);
        check("in_ready_busy", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_score = 8'($urandom);
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_idx", res_idx, exp_idx);
            check("hold_correct", res_correct, exp_c);
            check("hold_in_ready", in_ready, 0);
            for (int i = 0; i < 10; i++)
                check("hold_scores", scores[i], vec[i] & 32'hFF);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        in_valid  = 1'b0;
        check("in_ready_after", in_ready, 1);
        check("res_valid_after", res_valid, 0);
        check("start_once", start_cnt - s0, 1);
    endtask

    task automatic run_vec(input int hold, input bit clr_upd);
        int acc;
        send(10, acc);
        wait_result(acc, hold, clr_upd);
    endtask

    initial begin
        int acc;
        int s0;
        reset = 1'b1; in_valid = 1'b0; in_score = '0; in_label = '0;
        res_ready = 1'b0; clear_cnt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_start", start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_idx", res_idx, 0);
        check("rst_res_correct", res_correct, 0);
        check("rst_total", total_cnt, 0);
        check("rst_correct", correct_cnt, 0);
        reset = 1'b0;

        // Directed vector, label 2 wins
        vec = '{3, -5, 17, 0, 2, -128, 16, 1, 9, 4};
        exp_label = 2;
        run_vec(0, 0);

        // All negative, label 7, then back-to-back random vector
        for (int i = 0; i < 10; i++) vec[i] = -(i + 1);
        exp_label = 7;
        run_vec(0, 0);
        rand_vec();
        exp_label = ref_argmax();
        run_vec(0, 0);

        // Consumer stalls for 20 cycles
        rand_vec();
        exp_label = $urandom_range(0, 9);
        run_vec(20, 0);

        // Drive counters to saturation with correct results
        for (int k = 0; k < 16; k++) begin
            rand_vec();
            exp_label = ref_argmax();
            run_vec(0, 0);
        end
        check("sat_total", total_cnt, SAT);
        check("sat_correct", correct_cnt, SAT);

        // Clear on the update cycle wins
        rand_vec();
        exp_label = ref_argmax();
        run_vec(0, 1);
        check("clr_total", total_cnt, 0);
        check("clr_correct", correct_cnt, 0);

        // Reset after 6 accepted scores discards the partial vector
        rand_vec();
        exp_label = ref_argmax();
        run_vec(0, 0);
        rand_vec();
        s0 = start_cnt;
        send(6, acc);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_total = 0;
        m_correct = 0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_total", total_cnt, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_no_start", start_cnt - s0, 0);
        rand_vec();
        exp_label = ref_argmax();
        run_vec(0, 0);

        // Out-of-range label never matches
        rand_vec();
        exp_label = 12;
        run_vec(0, 0);

        for (int k = 0; k < 6; k++) begin
            rand_vec();
            exp_label = ($urandom_range(0, 1) == 0) ? ref_argmax() : $urandom_range(0, 15);
            run_vec($urandom_range(0, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
